// File: rtl/sky130_as_sc_hs__chartest.sv
// Cell characterisation sequencer: shifts a test vector in serially, holds it on the
// cell inputs for SETTLE cycles, captures the cell outputs and shifts them back out.
module sky130_as_sc_hs__chartest #(
    parameter int N      = 8,
    parameter int SETTLE = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic         SI,
    output logic [N-1:0] VEC,
    input  logic [N-1:0] RES,
    output logic         SO,
    output logic         BUSY,
    output logic         DONE
);

    localparam int MAXC = (N > SETTLE) ? N : SETTLE;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] IN_LAST    = CW'(N - 1);
    localparam logic [CW-1:0] APPLY_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] DONE_AT    = CW'(N - 2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT_IN  = 2'd1,
        APPLY     = 2'd2,
        SHIFT_OUT = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [N-2:0]  shreg;
    logic [N-2:0]  cap;
    logic [N-1:0]  in_word;
    logic          last_in, last_apply, last_out;

    // The newest SI bit joins the top; after N samples the first bit sits at bit 0.
    assign in_word    = {SI, shreg};
    assign last_in    = (cnt == IN_LAST);
    assign last_apply = (cnt == APPLY_LAST);
    assign last_out   = (cnt == IN_LAST);
    assign BUSY       = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (START) state_next = SHIFT_IN;
            end
            SHIFT_IN: begin
                if (last_in) begin
                    state_next = APPLY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            APPLY: begin
                if (last_apply) begin
                    state_next = SHIFT_OUT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            SHIFT_OUT: begin
                if (last_out) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // SI and RES are only looked at on their own sample edges, so X elsewhere stays out.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg <= '0;
            cap   <= '0;
            VEC   <= '0;
            SO    <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                SHIFT_IN: begin
                    shreg <= in_word[N-1:1];
                    if (last_in) VEC <= in_word;
                end
                APPLY: begin
                    if (last_apply) begin
                        cap <= RES[N-1:1];
                        SO  <= RES[0];
                    end
                end
                SHIFT_OUT: begin
                    if (last_out) begin
                        SO   <= 1'b0;
                        DONE <= 1'b0;
                    end else begin
                        SO   <= cap[0];
                        cap  <= cap >> 1;
                        DONE <= (cnt == DONE_AT);
                    end
                end
                default: begin
                    SO   <= 1'b0;
                    DONE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sky130_as_sc_hs__chartest.sv
// Directed bench: N=8/SETTLE=4 instance with RES = ~VEC, plus an N=2/SETTLE=1 corner instance.
module tb_sky130_as_sc_hs__chartest;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, si;
    logic [7:0] vec8, res8;
    logic       so8, busy8, done8;
    logic       start2, si2;
    logic [1:0] vec2, res2;
    logic       so2, busy2, done2;

    int errs   = 0;
    int checks = 0;
    int done8_cnt = 0;

    always #5 clk = ~clk;

    assign res8 = ~vec8;
    assign res2 = 2'b01;

    sky130_as_sc_hs__chartest #(.N(8), .SETTLE(4)) dut8 (
        .CLK(clk), .RST(rst), .START(start), .SI(si),
        .VEC(vec8), .RES(res8), .SO(so8), .BUSY(busy8), .DONE(done8)
    );

    sky130_as_sc_hs__chartest #(.N(2), .SETTLE(1)) dut2 (
        .CLK(clk), .RST(rst), .START(start2), .SI(si2),
        .VEC(vec2), .RES(res2), .SO(so2), .BUSY(busy2), .DONE(done2)
    );

    always @(posedge clk) if (done8) done8_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // START edge followed by eight SI edges; VEC must only change on the last one.
    task automatic shift_in(input logic [7:0] v, input logic [7:0] prev);
        start = 1'b1;
        step();
        check("busy_after_start", 32'(busy8), 1);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            si = v[i];
            step();
            if (i < 7) check("vec_held_during_shift", 32'(vec8), 32'(prev));
        end
        si = 1'b0;
        check("vec_loaded", 32'(vec8), 32'(v));
    endtask

    task automatic seq8(input logic [7:0] v, input logic [7:0] prev, input bit restart);
        logic [7:0] r;
        int d0;
        r  = ~v;
        d0 = done8_cnt;
        shift_in(v, prev);
        for (int j = 0; j < 4; j++) begin
            step();
            start = (restart && j == 1);
            check("vec_apply", 32'(vec8), 32'(v));
            check("busy_apply", 32'(busy8), 1);
            if (j < 3) check("so_apply", 32'(so8), 0);
            else       check("so_bit0", 32'(so8), 32'(r[0]));
        end
        start = 1'b0;
        for (int b = 1; b < 8; b++) begin
            step();
            check("so_bit", 32'(so8), 32'(r[b]));
            check("done_bit", 32'(done8), (b == 7) ? 1 : 0);
        end
        step();
        check("idle_busy", 32'(busy8), 0);
        check("idle_so", 32'(so8), 0);
        check("idle_done", 32'(done8), 0);
        check("done_count", 32'(done8_cnt - d0), 1);
        repeat (3) step();
        check("no_queued_start", 32'(busy8), 0);
        check("vec_kept", 32'(vec8), 32'(v));
    endtask

    task automatic wait_idle;
        for (int c = 0; c < 60 && busy8; c++) step();
        check("idle_timeout", 32'(busy8), 0);
    endtask

    initial begin
        int d0;
        int hits;
        int first_at, second_at;
        rst = 1'b1; start = 1'b0; si = 1'b0; start2 = 1'b0; si2 = 1'b0;
        repeat (2) step();
        check("rst_vec", 32'(vec8), 0);
        check("rst_so", 32'(so8), 0);
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_vec2", 32'(vec2), 0);
        rst = 1'b0;
        step();

        seq8(8'h4D, 8'h00, 1'b0);
        seq8(8'hA6, 8'h4D, 1'b1);

        // Reset in the middle of SHIFT_OUT while SO carries RES[3].
        d0 = done8_cnt;
        shift_in(8'h35, 8'hA6);
        repeat (4) step();
        repeat (3) step();
        check("so_before_rst", 32'(so8), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_so", 32'(so8), 0);
        check("async_rst_vec", 32'(vec8), 0);
        check("async_rst_busy", 32'(busy8), 0);
        check("async_rst_done", 32'(done8), 0);
        #1 rst = 1'b0;
        repeat (25) step();
        check("rst_abort_idle", 32'(busy8), 0);
        check("rst_abort_nodone", 32'(done8_cnt - d0), 0);

        // START already high when reset releases is taken on the next edge.
        d0 = done8_cnt;
        rst = 1'b1; start = 1'b1;
        #1 rst = 1'b0;
        step();
        check("start_after_rst", 32'(busy8), 1);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            si = (i == 0 || i == 7);
            step();
        end
        si = 1'b0;
        check("vec_after_rst_start", 32'(vec8), 32'h81);
        wait_idle();
        check("done_after_rst_start", 32'(done8_cnt - d0), 1);

        // START held high: back-to-back 21-edge sequences.
        step();
        d0 = done8_cnt;
        hits = 0; first_at = -1; second_at = -1;
        start = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            if (done8) begin
                if (hits == 0) first_at = c;
                else if (hits == 1) second_at = c;
                hits++;
            end
        end
        start = 1'b0;
        check("b2b_pulses", 32'(hits), 2);
        check("b2b_first", 32'(first_at), 19);
        check("b2b_period", 32'(second_at - first_at), 21);
        wait_idle();
        check("b2b_total_done", 32'(done8_cnt - d0), 3);

        // N=2, SETTLE=1 corner.
        start2 = 1'b1;
        step();
        check("c2_busy", 32'(busy2), 1);
        start2 = 1'b0;
        si2 = 1'b1;
        step();
        check("c2_vec_partial", 32'(vec2), 0);
        step();
        si2 = 1'b0;
        check("c2_vec", 32'(vec2), 3);
        step();
        check("c2_so0", 32'(so2), 1);
        check("c2_done0", 32'(done2), 0);
        step();
        check("c2_so1", 32'(so2), 0);
        check("c2_done1", 32'(done2), 1);
        step();
        check("c2_idle", 32'(busy2), 0);
        check("c2_done_clr", 32'(done2), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sky130_as_sc_hs__chartest.md
SKY130_AS_SC_HS__CHARTEST -- requirements
Module: sky130_as_sc_hs__chartest

Interface
REQ-001 Parameter: N, default 8, width of the test vector and of the result word (legal 2..32).
REQ-002 Parameter: SETTLE, default 4, number of CLK cycles the vector is held before capture (legal 1..255).
REQ-003 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous and active-high.
REQ-005 Port: START  input  1  request a test sequence; sampled only in IDLE.
REQ-006 Port: SI  input  1  serial vector in, LSB first.
REQ-007 Port: VEC  output  N  registered test vector driven onto the cell-under-test inputs.
REQ-008 Port: RES  input  N  cell-under-test outputs, sampled at capture.
REQ-009 Port: SO  output  1  registered serial result out, LSB first.
REQ-010 Port: BUSY  output  1  high whenever state is not IDLE.
REQ-011 Port: DONE  output  1  one-cycle pulse marking the last serial-out bit.

Function
REQ-012 FSM states: IDLE, SHIFT_IN, APPLY, SHIFT_OUT; one-hot or binary encoding is free; no other states are reachable.
REQ-013 IDLE: START=1 at edge k -> SHIFT_IN from edge k; bit counter cleared to 0.
REQ-014 SHIFT_IN: SI sampled on edges k+1..k+N; the sample on edge k+i lands in vector bit i-1.
REQ-015 On edge k+N, VEC loads the complete assembled vector in one step (no partial vector ever visible on VEC) and state -> APPLY.
REQ-016 APPLY: VEC held for exactly SETTLE cycles; on edge k+N+SETTLE, RES captured into the output register and state -> SHIFT_OUT.
REQ-017 SHIFT_OUT: SO is RES[0] for the cycle after capture, then RES[1], ..., RES[N-1], one bit per cycle (N cycles total).
REQ-018 DONE is high during the cycle SO carries RES[N-1]; on the following edge state -> IDLE, DONE -> 0.
REQ-019 Total latency START-sample to return to IDLE: N + SETTLE + N + 1 edges.
REQ-020 VEC holds its last value after the sequence until the next SHIFT_IN completes; SO returns to 0 in IDLE.
REQ-021 START while BUSY=1 is ignored (no queueing, no restart); START held high continuously causes back-to-back sequences, with a new one beginning on the first edge in IDLE.
REQ-022 SI and RES are don't-care outside their sample edges; X on them outside those edges does not propagate.
REQ-023 Counters are sized ceil(log2(max(N,SETTLE)+1)) bits and never wrap within a state.

Reset
REQ-024 RST=1 forces, asynchronously: state IDLE, counters 0, VEC=0, SO=0, BUSY=0, DONE=0, shift and capture registers 0.
REQ-025 RST asserted mid-sequence (any state) aborts it; after deassertion the block idles until a fresh START.
REQ-026 RST deassertion takes effect on the next rising CLK edge; START high on that edge is accepted.

Verification
REQ-027 N=8, SETTLE=4: START pulse, SI stream 1,0,1,1,0,0,1,0 -> VEC=8'h4D after 8 edges, held 4 cycles, BUSY high throughout.
REQ-028 RES tied to ~VEC with the same stimulus -> SO sequence 0,1,0,0,1,1,0,1; DONE high only on the 8th bit; IDLE after 21 edges.
REQ-029 START pulsed again at the 3rd APPLY cycle -> ignored; exactly one DONE; VEC unchanged.
REQ-030 RST pulse during SHIFT_OUT bit 3 -> SO, VEC, BUSY, DONE all 0 immediately, without waiting for a clock edge; no DONE afterwards.
REQ-031 START held high for 50 cycles -> back-to-back sequences, each 21 edges long; DONE pulses every 21 cycles.
REQ-032 N=2, SETTLE=1 corner: SI 1,1 -> VEC=2'b11; RES=2'b01 -> SO 1,0; DONE on the 2nd bit; total 6 edges.
